mips_muldiv_unit: RTL



---
 rtl/mips_muldiv_pkg.sv | 21 ++
 rtl/mips_muldiv_core.sv | 70 +++++++
 rtl/mips_muldiv_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_pkg.sv
// rtl/mips_muldiv_pkg.sv - shared opcodes, FSM encoding and constants for the mul/div unit
package mips_muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [DEF_WIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } state_t;

endpackage

// File: rtl/mips_muldiv_core.sv
// rtl/mips_muldiv_core.sv - shared iterative shift-add / restoring shift-subtract datapath
module mips_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_is_div,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_acc,
    output logic               o_last
);
    localparam int CW = $clog2(WIDTH);

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;

    // One multiply or divide step per enabled cycle; load seeds operands
    always_comb begin
        acc_d = acc_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
        if (i_load) begin
            acc_d = {{WIDTH{1'b0}}, i_a};
            b_d   = i_b;
            cnt_d = '0;
        end else if (i_step) begin
            cnt_d = cnt_q + 1'b1;
            if (i_is_div) begin
                // trial[WIDTH] is the borrow: keep the old remainder if it went negative
                if (!trial[WIDTH]) begin
                    acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                end
            end else begin
                if (acc_q[0]) begin
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            acc_q <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_acc  = acc_q;
    assign o_last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - MIPS HI/LO multiply/divide unit with sign handling and control FSM
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_rs,
    input  logic [WIDTH-1:0] i_rt,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    state_t state_q, state_d;

    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   rs_q, rs_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               accept, md_start, core_load, core_step, core_last;
    logic               sgn, rs_neg, rt_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc, prod;
    logic [WIDTH-1:0]   quo, rem;

    assign accept   = i_start && (state_q == ST_IDLE);
    assign md_start = accept && !i_op[2];

    // Signed ops are the even opcodes; operands become magnitudes for the core
    always_comb begin
        sgn    = ~i_op[0];
        rs_neg = sgn & i_rs[WIDTH-1];
        rt_neg = sgn & i_rt[WIDTH-1];
        a_mag  = rs_neg ? -i_rs : i_rs;
        b_mag  = rt_neg ? -i_rt : i_rt;
    end

    mips_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (core_load),
        .i_step   (core_step),
        .i_is_div (is_div_q),
        .i_a      (a_mag),
        .i_b      (b_mag),
        .o_acc    (acc),
        .o_last   (core_last)
    );

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (md_start) state_d = ST_CALC;
            ST_CALC: if (core_last) state_d = ST_SIGN;
            ST_SIGN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_busy    = (state_q != ST_IDLE);
        core_load = md_start;
        core_step = (state_q == ST_CALC);
    end

    // Latch op attributes at accept, apply sign correction and write HI/LO at the end
    always_comb begin
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        rs_d      = rs_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = (state_q == ST_SIGN);
        prod      = neg_q ? -acc : acc;
        quo       = acc[WIDTH-1:0];
        rem       = acc[2*WIDTH-1:WIDTH];
        if (md_start) begin
            is_div_d  = i_op[1];
            neg_d     = rs_neg ^ rt_neg;
            rem_neg_d = rs_neg;
            div0_d    = i_op[1] && (i_rt == '0);
            rs_d      = i_rs;
        end
        if (accept && i_op == OP_MTHI) hi_d = i_rs;
        if (accept && i_op == OP_MTLO) lo_d = i_rs;
        if (state_q == ST_SIGN) begin
            if (!is_div_q) begin
                hi_d = prod[2*WIDTH-1:WIDTH];
                lo_d = prod[WIDTH-1:0];
            end else if (div0_q) begin
                hi_d = rs_q;
                lo_d = WIDTH'(DIV0_QUOTIENT);
            end else begin
                hi_d = rem_neg_q ? -rem : rem;
                lo_d = neg_q ? -quo : quo;
            end
        end
    end

    // Architectural and control registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            rs_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            rs_q      <= rs_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule
